// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns single-beat host commands into AXI-Lite read/write
// transactions, one outstanding at a time, and returns each completion on a
// response handshake. A per-transaction watchdog aborts a hung slave with an
// error response so the command source never stalls forever.
module axil_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  // command handshake
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  // response handshake
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_write,
  output logic        rsp_timeout,
  output logic        busy,
  // AXI-Lite write address / data / response
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp,
  // AXI-Lite read address / data
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp
);

  localparam int               CNT_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic             WD_EN       = (TIMEOUT_CYCLES > 0);
  // The abort fires on the edge that carries the count to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] WD_LAST     = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t           state, state_next;
  logic             aw_done, aw_done_next;
  logic             w_done, w_done_next;
  logic [CNT_W-1:0] wd_cnt, wd_cnt_next;

  logic        cmd_ready_next, busy_next;
  logic        rsp_valid_next, rsp_write_next, rsp_timeout_next;
  logic [31:0] rsp_rdata_next;
  logic [1:0]  rsp_resp_next;
  logic        m_awvalid_next, m_wvalid_next, m_bready_next, m_arvalid_next, m_rready_next;
  logic [31:0] m_awaddr_next, m_wdata_next, m_araddr_next;
  logic [3:0]  m_wstrb_next;

  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs, active, done_hs, wd_fire;

  // Word alignment discards the byte offset of the command address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cmd_addr[1:0];

  assign accept  = (state == IDLE) && cmd_valid && cmd_ready;
  assign aw_hs   = m_awvalid && m_awready;
  assign w_hs    = m_wvalid && m_wready;
  assign b_hs    = m_bvalid && m_bready;
  assign ar_hs   = m_arvalid && m_arready;
  assign r_hs    = m_rvalid && m_rready;
  assign rsp_hs  = rsp_valid && rsp_ready;
  assign active  = (state == WR_REQ) || (state == WR_RESP) || (state == RD_REQ) || (state == RD_RESP);
  assign done_hs = ((state == WR_RESP) && b_hs) || ((state == RD_RESP) && r_hs);
  assign wd_fire = WD_EN && active && (wd_cnt == WD_LAST) && !done_hs;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-output computation; the watchdog abort overrides the normal flow.
  always_comb begin
    state_next       = state;
    aw_done_next     = aw_done;
    w_done_next      = w_done;
    rsp_valid_next   = rsp_valid;
    rsp_rdata_next   = rsp_rdata;
    rsp_resp_next    = rsp_resp;
    rsp_write_next   = rsp_write;
    rsp_timeout_next = rsp_timeout;
    m_awvalid_next   = m_awvalid;
    m_awaddr_next    = m_awaddr;
    m_wvalid_next    = m_wvalid;
    m_wdata_next     = m_wdata;
    m_wstrb_next     = m_wstrb;
    m_bready_next    = m_bready;
    m_arvalid_next   = m_arvalid;
    m_araddr_next    = m_araddr;
    m_rready_next    = m_rready;

    if (accept) begin
      wd_cnt_next = '0;
    end else if (active) begin
      wd_cnt_next = wd_cnt + CNT_W'(1);
    end else begin
      wd_cnt_next = wd_cnt;
    end

    case (state)
      IDLE: begin
        if (accept) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          if (cmd_write) begin
            state_next     = WR_REQ;
            m_awvalid_next = 1'b1;
            m_wvalid_next  = 1'b1;
            m_awaddr_next  = {cmd_addr[31:2], 2'b00};
            m_wdata_next   = cmd_wdata;
            m_wstrb_next   = cmd_wstrb;
          end else begin
            state_next     = RD_REQ;
            m_arvalid_next = 1'b1;
            m_araddr_next  = {cmd_addr[31:2], 2'b00};
          end
        end else begin
          state_next = IDLE;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; each valid drops after its own handshake.
        if (aw_hs) begin
          m_awvalid_next = 1'b0;
          aw_done_next   = 1'b1;
        end else begin
          aw_done_next = aw_done;
        end
        if (w_hs) begin
          m_wvalid_next = 1'b0;
          w_done_next   = 1'b1;
        end else begin
          w_done_next = w_done;
        end
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_next    = WR_RESP;
          m_bready_next = 1'b1;
        end else begin
          state_next = WR_REQ;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_next       = RSP;
          m_bready_next    = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_rdata_next   = 32'h0000_0000;
          rsp_resp_next    = m_bresp;
          rsp_write_next   = 1'b1;
          rsp_timeout_next = 1'b0;
        end else begin
          state_next = WR_RESP;
        end
      end
      RD_REQ: begin
        if (ar_hs) begin
          state_next     = RD_RESP;
          m_arvalid_next = 1'b0;
          m_rready_next  = 1'b1;
        end else begin
          state_next = RD_REQ;
        end
      end
      RD_RESP: begin
        if (r_hs) begin
          state_next       = RSP;
          m_rready_next    = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_rdata_next   = m_rdata;
          rsp_resp_next    = m_rresp;
          rsp_write_next   = 1'b0;
          rsp_timeout_next = 1'b0;
        end else begin
          state_next = RD_RESP;
        end
      end
      RSP: begin
        // Return to IDLE first so no command is accepted on the response edge.
        if (rsp_hs) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
        end else begin
          state_next = RSP;
        end
      end
      default: begin
        state_next     = IDLE;
        m_awvalid_next = 1'b0;
        m_wvalid_next  = 1'b0;
        m_bready_next  = 1'b0;
        m_arvalid_next = 1'b0;
        m_rready_next  = 1'b0;
        rsp_valid_next = 1'b0;
      end
    endcase

    if (wd_fire) begin
      state_next       = RSP;
      m_awvalid_next   = 1'b0;
      m_wvalid_next    = 1'b0;
      m_bready_next    = 1'b0;
      m_arvalid_next   = 1'b0;
      m_rready_next    = 1'b0;
      rsp_valid_next   = 1'b1;
      rsp_rdata_next   = 32'h0000_0000;
      rsp_resp_next    = RESP_SLVERR;
      rsp_write_next   = (state == WR_REQ) || (state == WR_RESP);
      rsp_timeout_next = 1'b1;
    end else begin
      rsp_timeout_next = rsp_timeout_next;
    end

    cmd_ready_next = (state_next == IDLE);
    busy_next      = (state_next != IDLE);
  end

  // Registered outputs, handshake progress flags and watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      wd_cnt      <= '0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'h0000_0000;
      rsp_resp    <= 2'b00;
      rsp_write   <= 1'b0;
      rsp_timeout <= 1'b0;
      m_awvalid   <= 1'b0;
      m_awaddr    <= 32'h0000_0000;
      m_wvalid    <= 1'b0;
      m_wdata     <= 32'h0000_0000;
      m_wstrb     <= 4'h0;
      m_bready    <= 1'b0;
      m_arvalid   <= 1'b0;
      m_araddr    <= 32'h0000_0000;
      m_rready    <= 1'b0;
    end else begin
      aw_done     <= aw_done_next;
      w_done      <= w_done_next;
      wd_cnt      <= wd_cnt_next;
      cmd_ready   <= cmd_ready_next;
      busy        <= busy_next;
      rsp_valid   <= rsp_valid_next;
      rsp_rdata   <= rsp_rdata_next;
      rsp_resp    <= rsp_resp_next;
      rsp_write   <= rsp_write_next;
      rsp_timeout <= rsp_timeout_next;
      m_awvalid   <= m_awvalid_next;
      m_awaddr    <= m_awaddr_next;
      m_wvalid    <= m_wvalid_next;
      m_wdata     <= m_wdata_next;
      m_wstrb     <= m_wstrb_next;
      m_bready    <= m_bready_next;
      m_arvalid   <= m_arvalid_next;
      m_araddr    <= m_araddr_next;
      m_rready    <= m_rready_next;
    end
  end

endmodule
